// File: rtl/burst_mem_responder.sv
`default_nettype none
// ============================================================================
// burst_mem_responder : line-organised memory serving 4 x 64-bit beat bursts
// Revision: 1.0
// ============================================================================
module burst_mem_responder #(
  parameter int LINE_IDX_W = 8,
  parameter int LATENCY    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address_i,
  input  logic        read_i,
  input  logic        write_i,
  input  logic [63:0] burst_i,
  output logic [63:0] burst_o,
  output logic        resp_o,
  output logic        error_o
);

  localparam int         c_NUM_LINES = 1 << LINE_IDX_W;
  localparam logic [7:0] c_LAT_LOAD  = 8'(LATENCY - 1);
  localparam bit         c_LAT_ONE   = (LATENCY == 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_RBEAT = 3'd2,
    S_WBEAT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                  r_state;
  logic [7:0]              r_cnt;
  logic [1:0]              r_k;
  logic [LINE_IDX_W-1:0]   r_idx;
  logic                    r_dir;   // 1 = write burst
  logic                    r_err;
  logic [255:0]            r_mem [c_NUM_LINES];

  state_t                  w_next;
  logic [7:0]              w_cnt_nxt;
  logic [1:0]              w_k_nxt;
  logic [LINE_IDX_W-1:0]   w_idx_nxt;
  logic                    w_dir_nxt;
  logic                    w_err_nxt;
  logic                    w_req_held;
  logic                    w_rd_beat;
  logic                    w_wr_beat;
  logic [7:0]              w_bit_base;

  // Address bits outside the line index are deliberately discarded.
  logic w_unused_lo;
  assign w_unused_lo = ^address_i[4:0];
  generate
    if (5 + LINE_IDX_W < 32) begin : g_unused_hi
      logic w_unused_hi;
      assign w_unused_hi = ^address_i[31:5+LINE_IDX_W];
    end
  endgenerate

  assign w_req_held = r_dir ? write_i : read_i;
  // A beat is only transferred while the initiator still holds its request.
  assign w_rd_beat  = (r_state == S_RBEAT) && w_req_held;
  assign w_wr_beat  = (r_state == S_WBEAT) && w_req_held;
  assign w_bit_base = {r_k, 6'b0};

  assign resp_o  = w_rd_beat || w_wr_beat;
  assign burst_o = w_rd_beat ? r_mem[r_idx][w_bit_base +: 64] : 64'd0;
  assign error_o = r_err;

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    w_k_nxt   = r_k;
    w_idx_nxt = r_idx;
    w_dir_nxt = r_dir;
    w_err_nxt = r_err;
    unique case (r_state)
      S_IDLE: begin
        if (read_i || write_i) begin
          w_idx_nxt = address_i[5 +: LINE_IDX_W];
          w_dir_nxt = ~read_i;
          w_cnt_nxt = c_LAT_LOAD;
          w_k_nxt   = 2'd0;
          if (read_i && write_i) w_err_nxt = 1'b1;
          if (c_LAT_ONE) w_next = read_i ? S_RBEAT : S_WBEAT;
          else           w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!w_req_held) begin
          w_next    = S_IDLE;
          w_err_nxt = 1'b1;
        end else if (r_cnt <= 8'd1) begin
          w_cnt_nxt = 8'd0;
          w_k_nxt   = 2'd0;
          w_next    = r_dir ? S_WBEAT : S_RBEAT;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      S_RBEAT, S_WBEAT: begin
        if (!w_req_held) begin
          w_next    = S_IDLE;
          w_err_nxt = 1'b1;
        end else begin
          w_k_nxt = r_k + 2'd1;
          if (r_k == 2'd3) w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_k_nxt = 2'd0;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_k     <= 2'd0;
      r_idx   <= '0;
      r_dir   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      r_k     <= w_k_nxt;
      r_idx   <= w_idx_nxt;
      r_dir   <= w_dir_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Storage is intentionally left unreset; each beat commits on its own edge.
  always_ff @(posedge clk) begin
    if (w_wr_beat) r_mem[r_idx][w_bit_base +: 64] <= burst_i;
  end

endmodule
`default_nettype wire

// File: tb/tb_burst_mem_responder.sv
`default_nettype none
// ============================================================================
// tb_burst_mem_responder : directed bench for burst_mem_responder (LATENCY=2)
// Revision: 1.0
// ============================================================================
module tb_burst_mem_responder;

  logic        clk;
  logic        rst;
  logic [31:0] address_i;
  logic        read_i;
  logic        write_i;
  logic [63:0] burst_i;
  logic [63:0] burst_o;
  logic        resp_o;
  logic        error_o;

  int passed;
  int total;

  localparam logic [7:0] c_RESP_WIN = 8'b0011_1100;

  burst_mem_responder #(
    .LINE_IDX_W(8),
    .LATENCY   (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .address_i(address_i),
    .read_i   (read_i),
    .write_i  (write_i),
    .burst_i  (burst_i),
    .burst_o  (burst_o),
    .resp_o   (resp_o),
    .error_o  (error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one full 8-cycle burst window and records what the DUT showed.
  task automatic run_burst(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [3:0][63:0] wd,
                           output logic [7:0] hist, output logic [3:0][63:0] got);
    hist = 8'd0;
    got  = '0;
    for (int c = 0; c < 8; c++) begin
      read_i    = rd && (c <= 5);
      write_i   = wr && (c <= 5);
      address_i = (c == 0) ? addr : 32'hDEAD_BEE0;
      burst_i   = (c >= 2 && c <= 5) ? wd[2'(c-2)] : 64'hBAD0_BAD0_BAD0_BAD0;
      #1;
      hist[c] = resp_o;
      if (c >= 2 && c <= 5) got[2'(c-2)] = burst_o;
      tick();
    end
  endtask

  logic [3:0][63:0] d_first, d_alias, d_sim, d_junk, d_old, d_new, got;
  logic [7:0]       hist;

  task automatic test_reset();
    rst = 1'b1; read_i = 1'b0; write_i = 1'b0; address_i = '0; burst_i = '0;
    tick(); tick();
    total++; if (resp_o !== 1'b0) $display("FAIL reset_resp got %b want 0", resp_o); else passed++;
    total++; if (burst_o !== 64'd0) $display("FAIL reset_burst got %h want 0", burst_o); else passed++;
    total++; if (error_o !== 1'b0) $display("FAIL reset_error got %b want 0", error_o); else passed++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    run_burst(1'b0, 1'b1, 32'h0000_0040, d_first, hist, got);
    total++; if (hist !== c_RESP_WIN) $display("FAIL wr_resp_window got %b want %b", hist, c_RESP_WIN); else passed++;
    run_burst(1'b1, 1'b0, 32'h0000_0040, d_junk, hist, got);
    total++; if (hist !== c_RESP_WIN) $display("FAIL rd_resp_window got %b want %b", hist, c_RESP_WIN); else passed++;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (got[k] !== d_first[k]) $display("FAIL rd_beat%0d got %h want %h", k, got[k], d_first[k]);
      else passed++;
    end
    total++; if (error_o !== 1'b0) $display("FAIL wr_rd_error got %b want 0", error_o); else passed++;
  endtask

  task automatic test_low_bits();
    run_burst(1'b1, 1'b0, 32'h0000_005F, d_junk, hist, got);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (got[k] !== d_first[k]) $display("FAIL lowbits_beat%0d got %h want %h", k, got[k], d_first[k]);
      else passed++;
    end
  endtask

  task automatic test_alias();
    run_burst(1'b0, 1'b1, 32'h0000_2040, d_alias, hist, got);
    run_burst(1'b1, 1'b0, 32'h0000_0040, d_junk, hist, got);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (got[k] !== d_alias[k]) $display("FAIL alias_beat%0d got %h want %h", k, got[k], d_alias[k]);
      else passed++;
    end
  endtask

  task automatic test_simultaneous();
    run_burst(1'b0, 1'b1, 32'h0000_0060, d_sim, hist, got);
    total++; if (error_o !== 1'b0) $display("FAIL sim_pre_error got %b want 0", error_o); else passed++;
    run_burst(1'b1, 1'b1, 32'h0000_0060, d_junk, hist, got);
    total++; if (hist !== c_RESP_WIN) $display("FAIL sim_resp_window got %b want %b", hist, c_RESP_WIN); else passed++;
    total++; if (got[1] !== d_sim[1]) $display("FAIL sim_read_beat1 got %h want %h", got[1], d_sim[1]); else passed++;
    total++; if (error_o !== 1'b1) $display("FAIL sim_error got %b want 1", error_o); else passed++;
    run_burst(1'b1, 1'b0, 32'h0000_0060, d_junk, hist, got);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (got[k] !== d_sim[k]) $display("FAIL sim_unchanged_beat%0d got %h want %h", k, got[k], d_sim[k]);
      else passed++;
    end
    total++; if (error_o !== 1'b1) $display("FAIL sim_error_sticky got %b want 1", error_o); else passed++;
  endtask

  task automatic test_abort();
    rst = 1'b1; #1; rst = 1'b0;
    total++; if (error_o !== 1'b0) $display("FAIL abort_pre_error got %b want 0", error_o); else passed++;
    run_burst(1'b0, 1'b1, 32'h0000_0080, d_old, hist, got);
    write_i = 1'b1; address_i = 32'h0000_0080; tick();
    address_i = 32'h0000_0000; tick();
    burst_i = d_new[0]; #1;
    total++; if (resp_o !== 1'b1) $display("FAIL abort_beat0_resp got %b want 1", resp_o); else passed++;
    tick();
    burst_i = d_new[1]; tick();
    write_i = 1'b0; burst_i = d_new[2]; #1;
    total++; if (resp_o !== 1'b0) $display("FAIL abort_resp_drop got %b want 0", resp_o); else passed++;
    tick();
    total++; if (resp_o !== 1'b0) $display("FAIL abort_resp_after got %b want 0", resp_o); else passed++;
    total++; if (error_o !== 1'b1) $display("FAIL abort_error got %b want 1", error_o); else passed++;
    run_burst(1'b1, 1'b0, 32'h0000_0080, d_junk, hist, got);
    total++; if (hist !== c_RESP_WIN) $display("FAIL abort_reread_window got %b want %b", hist, c_RESP_WIN); else passed++;
    total++; if (got[0] !== d_new[0]) $display("FAIL abort_beat0 got %h want %h", got[0], d_new[0]); else passed++;
    total++; if (got[1] !== d_new[1]) $display("FAIL abort_beat1 got %h want %h", got[1], d_new[1]); else passed++;
    total++; if (got[2] !== d_old[2]) $display("FAIL abort_beat2 got %h want %h", got[2], d_old[2]); else passed++;
    total++; if (got[3] !== d_old[3]) $display("FAIL abort_beat3 got %h want %h", got[3], d_old[3]); else passed++;
  endtask

  task automatic test_async_reset();
    read_i = 1'b1; address_i = 32'h0000_0040; tick();
    tick(); tick(); tick();
    #1;
    total++; if (resp_o !== 1'b1) $display("FAIL ar_beat2_resp got %b want 1", resp_o); else passed++;
    total++; if (burst_o !== d_alias[2]) $display("FAIL ar_beat2_data got %h want %h", burst_o, d_alias[2]); else passed++;
    #1 rst = 1'b1;
    #1;
    total++; if (resp_o !== 1'b0) $display("FAIL ar_resp_immediate got %b want 0", resp_o); else passed++;
    total++; if (burst_o !== 64'd0) $display("FAIL ar_burst_immediate got %h want 0", burst_o); else passed++;
    #1 rst = 1'b0; read_i = 1'b0;
    tick();
    run_burst(1'b1, 1'b0, 32'h0000_0040, d_junk, hist, got);
    total++; if (hist !== c_RESP_WIN) $display("FAIL ar_reread_window got %b want %b", hist, c_RESP_WIN); else passed++;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (got[k] !== d_alias[k]) $display("FAIL ar_reread_beat%0d got %h want %h", k, got[k], d_alias[k]);
      else passed++;
    end
    total++; if (error_o !== 1'b0) $display("FAIL ar_error got %b want 0", error_o); else passed++;
  endtask

  initial begin
    passed  = 0;
    total   = 0;
    d_first = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
               64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    d_alias = {64'hDDDD_0000_DDDD_0004, 64'hCCCC_0000_CCCC_0003,
               64'hBBBB_0000_BBBB_0002, 64'hAAAA_0000_AAAA_0001};
    d_sim   = {64'h5EE0_0000_0000_0004, 64'h5EE0_0000_0000_0003,
               64'h5EE0_0000_0000_0002, 64'h5EE0_0000_0000_0001};
    d_junk  = {64'hFFFF_0000_FFFF_0004, 64'hFFFF_0000_FFFF_0003,
               64'hFFFF_0000_FFFF_0002, 64'hFFFF_0000_FFFF_0001};
    d_old   = {64'h0D0D_0000_0000_0004, 64'h0D0D_0000_0000_0003,
               64'h0D0D_0000_0000_0002, 64'h0D0D_0000_0000_0001};
    d_new   = {64'h9E90_0000_0000_0004, 64'h9E90_0000_0000_0003,
               64'h9E90_0000_0000_0002, 64'h9E90_0000_0000_0001};
    test_reset();
    test_write_read();
    test_low_bits();
    test_alias();
    test_simultaneous();
    test_abort();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
